// File: rtl/fft_pkg.sv
// Shared types and address helpers for the FFT memory sequencer.
// Helpers operate on MAX_AW-wide values; callers truncate to their ADDR_WIDTH.
package fft_pkg;

    localparam int unsigned MAX_AW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_WAIT,
        S_WR,
        S_UNLOAD,
        S_DONE
    } state_t;

    // Reverse the low aw bits of v; bits at and above aw come out as 0.
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v,
                                                 input int unsigned aw);
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_AW; i++) begin
            if (i < aw) begin
                r = r | (((v >> i) & MAX_AW'(1)) << (aw - 1 - i));
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_AW-1:0] span_mask(input int unsigned s);
        return (MAX_AW'(1) << s) - MAX_AW'(1);
    endfunction

    // Insert a 0 at bit position s of j: upper partner of the butterfly pair.
    function automatic logic [MAX_AW-1:0] bfly_a(input int unsigned s,
                                                 input logic [MAX_AW-1:0] j);
        return ((j >> s) << (s + 1)) | (j & span_mask(s));
    endfunction

    function automatic logic [MAX_AW-1:0] bfly_b(input int unsigned s,
                                                 input logic [MAX_AW-1:0] j);
        return bfly_a(s, j) | (MAX_AW'(1) << s);
    endfunction

    function automatic logic [MAX_AW-1:0] bfly_tw(input int unsigned s,
                                                  input logic [MAX_AW-1:0] j,
                                                  input int unsigned m);
        return (j & span_mask(s)) << (m - 1 - s);
    endfunction

endpackage

// File: rtl/fft_bfly_addr.sv
// Combinational butterfly address generator: (stage, butterfly) -> A, B, twiddle index.
module fft_bfly_addr
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int STAGE_W    = $clog2(ADDR_WIDTH + 1)
) (
    input  logic [STAGE_W-1:0]    s,
    input  logic [ADDR_WIDTH-2:0] j,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [ADDR_WIDTH-1:0] b,
    output logic [ADDR_WIDTH-2:0] tw
);

    logic [MAX_AW-1:0] j_ext;
    int unsigned       s_int;

    always_comb begin
        j_ext = MAX_AW'(j);
        s_int = 32'(s);
        a     = ADDR_WIDTH'(bfly_a(s_int, j_ext));
        b     = ADDR_WIDTH'(bfly_b(s_int, j_ext));
        tw    = (ADDR_WIDTH - 1)'(bfly_tw(s_int, j_ext, ADDR_WIDTH));
    end

endmodule

// File: rtl/fft_mem_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT on a dual-port RAM:
// bit-reversed load, paired read/wait/write butterflies, natural-order unload.
module fft_mem_sequencer
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int BFLY_LAT   = 2,
    parameter int STAGE_W    = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_roW,
    output logic                  ram_singlewrite,
    output logic [ADDR_WIDTH-1:0] ram_A_addr,
    output logic [ADDR_WIDTH-1:0] ram_B_addr,
    output logic [ADDR_WIDTH-2:0] tw_addr,
    output logic                  bfly_en,
    output logic [STAGE_W-1:0]    stage,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int WAIT_W = $clog2(BFLY_LAT + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-2:0] LAST_J    = '1;
    localparam logic [STAGE_W-1:0]    LAST_S    = STAGE_W'(ADDR_WIDTH - 1);
    localparam logic [WAIT_W-1:0]     LAST_WAIT = WAIT_W'(BFLY_LAT - 1);

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] load_cnt;
    logic [ADDR_WIDTH-1:0] u;
    logic [ADDR_WIDTH-2:0] j;
    logic [STAGE_W-1:0]    s;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [ADDR_WIDTH-1:0] bf_a;
    logic [ADDR_WIDTH-1:0] bf_b;
    logic [ADDR_WIDTH-2:0] bf_tw;
    logic                  last_bfly;

    fft_bfly_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .STAGE_W   (STAGE_W)
    ) u_bfly_addr (
        .s (s),
        .j (j),
        .a (bf_a),
        .b (bf_b),
        .tw(bf_tw)
    );

    assign last_bfly = (s == LAST_S) && (j == LAST_J);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (in_valid && load_cnt == LAST_ADDR) state_nx = S_RD;
            S_RD:     state_nx = S_WAIT;
            S_WAIT:   if (wait_cnt == LAST_WAIT) state_nx = S_WR;
            S_WR:     state_nx = last_bfly ? S_UNLOAD : S_RD;
            S_UNLOAD: if (u == LAST_ADDR) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
            u        <= '0;
            j        <= '0;
            s        <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    load_cnt <= '0;
                    u        <= '0;
                    j        <= '0;
                    s        <= '0;
                    wait_cnt <= '0;
                end
                S_LOAD:   if (in_valid) load_cnt <= load_cnt + 1'b1;
                S_RD:     wait_cnt <= '0;
                S_WAIT:   wait_cnt <= wait_cnt + 1'b1;
                S_WR: begin
                    j <= j + 1'b1;
                    if (j == LAST_J) s <= s + 1'b1;
                end
                S_UNLOAD: u <= u + 1'b1;
                default: ;
            endcase
        end
    end

    // RAM read data for address u appears one cycle later, so the bin index is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= (state == S_UNLOAD);
            out_idx   <= (state == S_UNLOAD) ? u : '0;
        end
    end

    always_comb begin
        in_ready        = 1'b0;
        ram_roW         = 1'b0;
        ram_singlewrite = 1'b0;
        ram_A_addr      = '0;
        ram_B_addr      = '0;
        tw_addr         = '0;
        bfly_en         = 1'b0;
        stage           = '0;
        case (state)
            S_LOAD: begin
                in_ready        = 1'b1;
                ram_singlewrite = in_valid;
                ram_A_addr      = ADDR_WIDTH'(bitrev(MAX_AW'(load_cnt), ADDR_WIDTH));
            end
            S_RD, S_WAIT, S_WR: begin
                ram_A_addr = bf_a;
                ram_B_addr = bf_b;
                tw_addr    = bf_tw;
                stage      = s;
                ram_roW    = (state == S_WR);
                bfly_en    = (state == S_WAIT) && (wait_cnt == '0);
            end
            S_UNLOAD: ram_A_addr = u;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
